// File: rtl/cpu_types_pkg.sv
// Shared CPU control types.
//   ctrl_state_t : pipeline controller FSM state (RUN, HALT)
//   regbits_t    : 5-bit architectural register index
package cpu_types_pkg;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } ctrl_state_t;

   typedef logic [4:0] regbits_t;

   // Register 0 is hardwired to zero, so it never carries a real dependency.
   localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector (purely combinational).
// Flags when the EX-stage instruction is a load whose destination is read by
// the ID-stage instruction, so the controller can insert one bubble.
// Ports:
//   idex_dren_i    : EX-stage instruction is a load
//   idex_dest_i    : EX-stage destination register
//   ifid_rs_i      : ID-stage rs
//   ifid_rt_i      : ID-stage rt
//   ifid_uses_rt_i : ID-stage instruction actually reads rt
//   lu_hazard_o    : load-use hazard present
module hazard_unit
   import cpu_types_pkg::*;
(
   input  logic       idex_dren_i,
   input  logic [4:0] idex_dest_i,
   input  logic [4:0] ifid_rs_i,
   input  logic [4:0] ifid_rt_i,
   input  logic       ifid_uses_rt_i,
   output logic       lu_hazard_o
);

   regbits_t dest;
   logic     rs_match;
   logic     rt_match;

   always_comb begin
      dest        = regbits_t'(idex_dest_i);
      rs_match    = (dest == regbits_t'(ifid_rs_i));
      rt_match    = ifid_uses_rt_i & (dest == regbits_t'(ifid_rt_i));
      lu_hazard_o = idex_dren_i & (dest != REG_ZERO) & (rs_match | rt_match);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer.
// Drives write-enable/flush for the if_id, id_ex, ex_mem and mem_wb latches
// and the PC, gates instruction/data memory requests, remembers split
// ihit/dhit arrival, inserts load-use bubbles, squashes wrong-path
// instructions on a taken branch and freezes the machine on halt.
// Ports:
//   CLK, nRST            : clock, asynchronous active-low reset
//   ihit, dhit           : instruction / data memory completion this cycle
//   exmem_dREN/dWEN      : load / store in MEM stage
//   exmem_halt           : halt in MEM stage
//   branch_taken         : MEM-stage redirect
//   idex_dREN, idex_dest : EX-stage load and its destination
//   ifid_rs/rt/uses_rt   : ID-stage source operands
//   pc_wen, *_wen        : PC and latch write enables
//   *_flush              : latch flushes (only honoured with wen)
//   imemREN              : gated instruction fetch request
//   dmemREN, dmemWEN     : gated data memory requests
//   halted               : machine is in HALT
//   stall_cnt            : saturating count of stalled RUN cycles
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned CNTW = 16
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            ihit,
   input  logic            dhit,
   input  logic            exmem_dREN,
   input  logic            exmem_dWEN,
   input  logic            exmem_halt,
   input  logic            branch_taken,
   input  logic            idex_dREN,
   input  logic [4:0]      idex_dest,
   input  logic [4:0]      ifid_rs,
   input  logic [4:0]      ifid_rt,
   input  logic            ifid_uses_rt,
   output logic            pc_wen,
   output logic            ifid_wen,
   output logic            idex_wen,
   output logic            exmem_wen,
   output logic            memwb_wen,
   output logic            ifid_flush,
   output logic            idex_flush,
   output logic            exmem_flush,
   output logic            memwb_flush,
   output logic            imemREN,
   output logic            dmemREN,
   output logic            dmemWEN,
   output logic            halted,
   output logic [CNTW-1:0] stall_cnt
);

   ctrl_state_t     state_q, state_d;
   logic            i_done_q, i_done_d;
   logic            d_done_q, d_done_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

   logic run;
   logic dacc;
   logic i_ok;
   logic d_ok;
   logic adv;
   logic lu_hazard;

   hazard_unit u_hazard_unit (
      .idex_dren_i    (idex_dREN),
      .idex_dest_i    (idex_dest),
      .ifid_rs_i      (ifid_rs),
      .ifid_rt_i      (ifid_rt),
      .ifid_uses_rt_i (ifid_uses_rt),
      .lu_hazard_o    (lu_hazard)
   );

   // A step completes only once both memories have answered; either answer
   // may arrive first and is remembered until the other shows up.
   always_comb begin
      run  = (state_q == RUN);
      dacc = exmem_dREN | exmem_dWEN;
      i_ok = ihit | i_done_q;
      d_ok = ~dacc | dhit | d_done_q;
      adv  = run & i_ok & d_ok;
   end

   // Memory request gating: never re-request an access that already completed.
   always_comb begin
      imemREN = run & ~i_done_q;
      dmemREN = exmem_dREN & ~d_done_q & run;
      dmemWEN = exmem_dWEN & ~d_done_q & run;
      halted  = (state_q == HALT);
   end

   // Next state, hit latches and stall counter.
   always_comb begin
      state_d     = state_q;
      i_done_d    = ~adv & (i_done_q | ihit);
      d_done_d    = ~adv & dacc & (d_done_q | dhit);
      stall_cnt_d = stall_cnt_q;

      if (adv && exmem_halt) begin
         state_d = HALT;
      end

      if (run && !adv && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNTW'(1);
      end
   end

   // Latch enable/flush priority: branch squash > load-use bubble > normal.
   always_comb begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_wen    = 1'b0;
      exmem_wen   = 1'b0;
      memwb_wen   = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;

      if (adv) begin
         idex_wen  = 1'b1;
         exmem_wen = 1'b1;
         memwb_wen = 1'b1;
         if (branch_taken) begin
            // MEM instruction retires; the three younger ones are wrong-path.
            pc_wen      = 1'b1;
            ifid_wen    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (lu_hazard) begin
            // Hold PC and IF/ID, push a bubble into ID/EX.
            idex_flush = 1'b1;
         end else begin
            pc_wen   = 1'b1;
            ifid_wen = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= RUN;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the four pipeline latches (if_id, id_ex, ex_mem, mem_wb) and the PC register.
- Generates every latch's wen/flush pair, gates the instruction- and data-memory request strobes, and tracks split ihit/dhit arrival.
- Inserts load-use bubbles, squashes wrong-path instructions on taken branches/jumps, and freezes the machine on halt.
- Sits beside the datapath in the CPU top level; the latches only obey flush when wen is high.

Parameters:
- CNTW, 16: width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  clock; single clock domain.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction memory returned data this cycle.
- dhit  in  1  data memory completed access this cycle.
- exmem_dREN  in  1  load in MEM stage (from ex_mem latch).
- exmem_dWEN  in  1  store in MEM stage.
- exmem_halt  in  1  halt in MEM stage.
- branch_taken  in  1  MEM-stage branch/jump redirect (pcselect != PC+4 and condition met).
- idex_dREN  in  1  load in EX stage.
- idex_dest  in  5  destination register of the EX-stage instruction.
- ifid_rs  in  5  rs of the ID-stage instruction.
- ifid_rt  in  5  rt of the ID-stage instruction.
- ifid_uses_rt  in  1  ID-stage instruction reads rt.
- pc_wen  out  1  PC update enable.
- ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1 each  latch write enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flushes.
- imemREN  out  1  gated instruction-fetch request.
- dmemREN, dmemWEN  out  1 each  gated data-memory requests.
- halted  out  1  machine halted.
- stall_cnt  out  CNTW  saturating count of stalled RUN cycles.

Behaviour:
- Registered state:
  - FSM state (RUN, HALT).
  - i_done: ihit already seen for the current step.
  - d_done: dhit already seen for the current step.
  - stall_cnt.
  - Reset: state=RUN, i_done=0, d_done=0, stall_cnt=0. Reset mid-operation discards partial hits immediately.
- Derived signals:
  - dacc = exmem_dREN | exmem_dWEN.
  - i_ok = ihit | i_done.
  - d_ok = ~dacc | dhit | d_done.
  - adv = (state==RUN) & i_ok & d_ok.
- Gating:
  - imemREN = (state==RUN) & ~i_done.
  - dmemREN = exmem_dREN & ~d_done & (state==RUN). dmemWEN is gated the same way.
  - A completed access is never re-requested while waiting for the other hit.
- Hit latches:
  - i_done <= ~adv & (i_done | ihit).
  - d_done <= ~adv & dacc & (d_done | dhit).
  - Both clear on the cycle after adv.
- adv=0: all wen and flush outputs = 0; the pipeline is frozen. stall_cnt increments if state==RUN, saturating at all-ones.
- adv=1, priority highest first:
  - branch_taken: all wen=1; ifid_flush=idex_flush=exmem_flush=1; memwb_flush=0. The MEM instruction retires and the three younger instructions are squashed.
  - Load-use (idex_dREN & idex_dest!=0 & (idex_dest==ifid_rs | (ifid_uses_rt & idex_dest==ifid_rt))): pc_wen=0, ifid_wen=0, idex_wen=1 with idex_flush=1 (bubble), exmem_wen=memwb_wen=1. Exactly one bubble per hazard.
  - Otherwise: all wen=1, all flush=0.
- Halt:
  - exmem_halt & adv: the same cycle's enables apply, then next state=HALT.
  - HALT: all wen/flush=0; imemREN, dmemREN and dmemWEN = 0; halted=1; stall_cnt holds. Exit only via nRST.
- Simultaneous cases:
  - branch_taken with exmem_halt: branch flushes apply, then HALT.
  - ihit and dhit in the same cycle: adv that cycle; neither latch sets.
  - Load-use while branch_taken: the branch wins and no bubble is inserted.

Decomposition:
- cpu_types_pkg holds:
  - ctrl_state_t enum {RUN, HALT}.
  - regbits_t (5-bit register index).
- One combinational sub-module, hazard_unit, performs the load-use compare and outputs lu_hazard.
- pipeline_ctrl holds the FSM, hit latches, priority mux and counter.

Test Plan:
- Hit ordering: ihit=1, no dacc → adv each cycle; all wen=1, flush=0, stall_cnt stays 0.
- Split hits: exmem_dREN=1, ihit at cycle 1, dhit at cycle 4 → imemREN drops after cycle 1, wens=0 for cycles 1–3, wen=1 at cycle 4, stall_cnt=3, d_done/i_done=0 at cycle 5.
- Load-use: idex_dREN=1, idex_dest=5, ifid_rs=5, adv → pc_wen=ifid_wen=0, idex_flush=1. Repeat with idex_dest=0 → no bubble.
- Branch and hazard: branch_taken=1 together with a load-use hazard → ifid/idex/exmem flush=1, pc_wen=1, memwb_flush=0.
- Halt: exmem_halt=1 with adv → next cycle halted=1, imemREN=0, all wen=0; stays for 10 cycles; nRST low mid-HALT → RUN, stall_cnt=0.
- Counter saturation: CNTW=4 with 20 stalled cycles → stall_cnt=15.
